// File: rtl/uart_rx_fifo_param.sv
// UART receiver with phase-accumulator sample ticks, 3-sample majority vote,
// configurable frame format, break detection and a tagged ready/valid FIFO.
module uart_rx_fifo_param #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_parity_err,
    output logic                        m_frame_err,
    output logic                        m_break,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        rx_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int ENT_W = DATA_BITS + 3;
    localparam logic [63:0] INC64 =
        ((64'(BAUD_RATE) * 64'(OVERSAMPLE) << ACC_W) + 64'(CLOCK_FREQ) / 64'd2) / 64'(CLOCK_FREQ);
    localparam logic [ACC_W-1:0] INC       = INC64[ACC_W-1:0];
    localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] DEPTH     = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;

    state_t               state, state_next;
    logic                 sync1, rx_s, rx_prev;
    logic [1:0]           sync_vld;
    logic                 start_edge;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W:0]       acc_sum;
    logic                 tick, decide, vote;
    logic [CNT_W-1:0]     tick_cnt;
    logic [1:0]           samp;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err, frm_err, par_zero;
    logic                 push;
    logic [ENT_W-1:0]     push_entry;
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [ENT_W-1:0]     head;
    logic [LVL_W-1:0]     wr_cnt, rd_cnt;
    logic                 pop, full, wr_en;

    // sync_vld keeps the reset value of the synchroniser from looking like a real high line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
            rx_prev  <= 1'b0;
        end else begin
            sync1    <= rx;
            rx_s     <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            rx_prev  <= rx_s & sync_vld[1];
        end
    end

    assign start_edge = (state == IDLE) && sync_vld[1] && rx_prev && !rx_s;
    assign acc_sum    = {1'b0, acc} + {1'b0, INC};
    assign tick       = acc_sum[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            tick_cnt <= '0;
            samp     <= 2'b11;
        end else if (start_edge) begin
            acc      <= '0;
            tick_cnt <= '0;
        end else begin
            acc <= acc_sum[ACC_W-1:0];
            if (tick && state != IDLE && state != BRK_WAIT) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_W'(1);
                if (tick_cnt == TICK_LO)  samp[0] <= rx_s;
                if (tick_cnt == TICK_MID) samp[1] <= rx_s;
            end
        end
    end

    assign vote   = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign decide = tick && (tick_cnt == TICK_HI) && (state inside {START, DATA, PAR, STOP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Frames complete at the mid-bit decision of the last stop bit, so push happens there
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_entry = {1'b0, frm_err | ~vote, par_err, shift};
        case (state)
            IDLE:     if (start_edge) state_next = START;
            START:    if (decide) state_next = vote ? IDLE : DATA;
            DATA:     if (decide && bit_idx == DATA_LAST) state_next = (PARITY != 0) ? PAR : STOP;
            PAR:      if (decide) state_next = STOP;
            STOP: begin
                if (decide) begin
                    if (bit_idx == 4'd0 && !vote && shift == '0 && par_zero) begin
                        push       = 1'b1;
                        push_entry = {1'b1, 1'b1, 1'b0, {DATA_BITS{1'b0}}};
                        state_next = BRK_WAIT;
                    end else if (bit_idx == STOP_LAST) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            BRK_WAIT: if (rx_s) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx  <= '0;
            shift    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            par_zero <= 1'b1;
        end else if (decide) begin
            case (state)
                START: begin
                    bit_idx  <= '0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                    par_zero <= 1'b1;
                end
                DATA: begin
                    shift   <= {vote, shift[DATA_BITS-1:1]};
                    bit_idx <= (bit_idx == DATA_LAST) ? 4'd0 : bit_idx + 4'd1;
                end
                PAR: begin
                    par_err  <= (PARITY == 1) ? (vote == ^shift) : (vote != ^shift);
                    par_zero <= ~vote;
                end
                STOP: begin
                    frm_err <= frm_err | ~vote;
                    bit_idx <= bit_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign fifo_level = wr_cnt - rd_cnt;
    assign m_valid    = (fifo_level != '0);
    assign pop        = m_valid && m_ready;
    assign full       = (fifo_level == DEPTH);
    assign wr_en      = push && (!full || pop);

    // A set of overrun in the same cycle as clr_overrun takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_cnt <= wr_cnt + LVL_W'(1);
            if (pop)   rd_cnt <= rd_cnt + LVL_W'(1);
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_overrun)     overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[PTR_W-1:0]] <= push_entry;
    end

    assign head = mem[rd_cnt[PTR_W-1:0]];
    assign {m_break, m_frame_err, m_parity_err, m_data} = m_valid ? head : '0;
    assign rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Randomised bench for uart_rx_fifo_param: an 8E1 serial driver feeds a
// queue-based model of expected FIFO entries that is checked every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo_param;
    localparam int DEPTH  = 4;
    localparam int BIT_NS = 1000;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, m_ready = 1'b0, clr_overrun = 1'b0;
    logic [7:0] m_data;
    logic       m_parity_err, m_frame_err, m_break, m_valid, overrun, rx_busy;
    logic [2:0] fifo_level;
    int         total = 0, bad = 0;
    int         ready_mode = 0;
    bit         model_overrun = 1'b0;

    typedef struct packed {
        logic       brk;
        logic       frm;
        logic       par;
        logic [7:0] data;
    } entry_t;
    entry_t exp_q[$];

    always #10 clk = ~clk;

    uart_rx_fifo_param #(
        .CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16), .ACC_W(24),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
        .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .overrun(overrun), .clr_overrun(clr_overrun),
        .rx_busy(rx_busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'(ones % 2);
    endfunction

    // Expected entry from the line-level contents of one frame
    function automatic entry_t model_entry(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        entry_t e;
        if (d == 8'h00 && !par_bit && !stop_bit) begin
            e.brk = 1'b1; e.frm = 1'b1; e.par = 1'b0; e.data = 8'h00;
        end else begin
            e.brk = 1'b0; e.frm = !stop_bit; e.par = (par_bit != even_par(d)); e.data = d;
        end
        return e;
    endfunction

    function automatic void model_push(input entry_t e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else model_overrun = 1'b1;
    endfunction

    task automatic apply_stimulus(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                                  input int bit_ns, input int gap_ns, input bit timing_chk);
        @(negedge clk);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = par_bit;
        #(bit_ns);
        rx = stop_bit;
        model_push(model_entry(d, par_bit, stop_bit));
        if (timing_chk) begin
            #(bit_ns / 2);
            check_output("valid_before_stop_mid", m_valid, 0);
            #(bit_ns * 3 / 10);
            check_output("valid_after_stop_mid", m_valid, 1);
            #(bit_ns - bit_ns / 2 - bit_ns * 3 / 10);
        end else begin
            #(bit_ns);
        end
        rx = 1'b1;
        #(gap_ns);
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 1;
        while ((exp_q.size() != 0 || m_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_level", fifo_level, 0);
        check_output("drain_model_empty", exp_q.size(), 0);
        ready_mode = 0;
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = logic'($urandom_range(0, 1));
        endcase
    end

    // Head of the DUT FIFO must always match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_entry", m_valid, 0);
            end else begin
                check_output("head_entry", {m_break, m_frame_err, m_parity_err, m_data}, exp_q[0]);
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p, s;
        rst_n = 1'b0;
        rx = 1'b0;
        ready_mode = 1;
        repeat (5) @(negedge clk);
        check_output("rst_valid", m_valid, 0);
        check_output("rst_data", m_data, 0);
        check_output("rst_flags", {m_break, m_frame_err, m_parity_err}, 0);
        check_output("rst_level", fifo_level, 0);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_busy", rx_busy, 0);

        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check_output("low_release_busy", rx_busy, 0);
        check_output("low_release_level", fifo_level, 0);
        rx = 1'b1;
        repeat (100) @(negedge clk);

        ready_mode = 0;
        repeat (2) @(negedge clk);
        apply_stimulus(8'hA5, even_par(8'hA5), 1'b1, BIT_NS, BIT_NS, 1'b1);
        check_output("t1_data", m_data, 8'hA5);
        check_output("t1_flags", {m_break, m_frame_err, m_parity_err}, 0);
        check_output("t1_level", fifo_level, 1);
        drain();

        apply_stimulus(8'h03, 1'b1, 1'b1, BIT_NS, BIT_NS, 1'b0);
        check_output("t2_bad_par_data", m_data, 8'h03);
        check_output("t2_bad_par_flag", m_parity_err, 1);
        drain();
        apply_stimulus(8'h03, 1'b0, 1'b1, BIT_NS, BIT_NS, 1'b0);
        check_output("t2_good_par_flag", m_parity_err, 0);
        drain();

        @(negedge clk);
        rx = 1'b0;
        #(10 * BIT_NS);
        model_push(model_entry(8'h00, 1'b0, 1'b0));
        #(10 * BIT_NS);
        check_output("t3_level", fifo_level, 1);
        check_output("t3_entry", {m_break, m_frame_err, m_parity_err, m_data}, 11'h600);
        check_output("t3_busy_low", rx_busy, 1);
        rx = 1'b1;
        #(2 * BIT_NS);
        check_output("t3_busy_high", rx_busy, 0);
        check_output("t3_level_after", fifo_level, 1);
        drain();
        apply_stimulus(8'h5A, even_par(8'h5A), 1'b1, BIT_NS, BIT_NS, 1'b0);
        check_output("t3_next_data", m_data, 8'h5A);
        drain();

        for (int i = 1; i <= 6; i++) begin
            d = 8'(i);
            apply_stimulus(d, even_par(d), 1'b1, BIT_NS, BIT_NS, 1'b0);
        end
        check_output("t4_level", fifo_level, 4);
        check_output("t4_overrun", overrun, 1);
        check_output("t4_model_overrun", overrun, 32'(model_overrun));
        check_output("t4_head", m_data, 8'h01);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        model_overrun = 1'b0;
        check_output("t4_overrun_clr", overrun, 0);
        drain();

        @(negedge clk);
        rx = 1'b0;
        #300;
        check_output("t5_busy_during", rx_busy, 1);
        #20;
        rx = 1'b1;
        #680;
        check_output("t5_busy_after", rx_busy, 0);
        check_output("t5_level", fifo_level, 0);

        ready_mode = 2;
        for (int i = 0; i < 16; i++)
            apply_stimulus(8'h55, even_par(8'h55), 1'b1, (i % 2 == 0) ? 970 : 1030, BIT_NS, 1'b0);
        drain();

        apply_stimulus(8'h11, even_par(8'h11), 1'b1, BIT_NS, BIT_NS, 1'b0);
        check_output("t6_pre_reset_level", fifo_level, 1);
        @(negedge clk);
        rx = 1'b0;
        #(3 * BIT_NS + 15);
        rst_n = 1'b0;
        exp_q.delete();
        model_overrun = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_output("t6_rst_level", fifo_level, 0);
        check_output("t6_rst_valid", m_valid, 0);
        check_output("t6_rst_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        apply_stimulus(8'h3C, even_par(8'h3C), 1'b1, BIT_NS, BIT_NS, 1'b0);
        check_output("t6_post_reset_data", m_data, 8'h3C);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            p = even_par(d) ^ ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 9) != 0);
            apply_stimulus(d, p, s, $urandom_range(980, 1020), $urandom_range(1000, 2000), 1'b0);
        end
        drain();
        check_output("final_overrun", overrun, 32'(model_overrun));
        check_output("final_busy", rx_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
